// File: rtl/io_bypass_history.sv
// io_bypass_history: last-DEPTH write-back history with per-byte, youngest-first forwarding and pending-load stall.
// Optional macro IO_BYPASS_INPUT_FORWARD_EN: the incoming entry also forwards in its own cycle.
module io_bypass_history #(
  parameter int DEPTH          = 2,
  parameter int NUM_READ       = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                               i_clock,
  input  logic                               i_reset,
  input  logic                               i_flush,
  input  logic                               i_advance,
  input  logic                               i_in_valid,
  input  logic [REG_ADDR_WIDTH-1:0]          i_in_register,
  input  logic [DATA_WIDTH/8-1:0]            i_in_strobe,
  input  logic [DATA_WIDTH-1:0]              i_in_data,
  input  logic                               i_in_data_valid,
  input  logic                               i_resolve_valid,
  input  logic [DATA_WIDTH-1:0]              i_resolve_data,
  input  logic [NUM_READ*REG_ADDR_WIDTH-1:0] i_read_register,
  input  logic [NUM_READ*DATA_WIDTH-1:0]     i_read_regfile,
  output logic [NUM_READ*DATA_WIDTH-1:0]     o_read_data,
  output logic [NUM_READ-1:0]                o_read_stall,
  output logic [DEPTH-1:0]                   o_history_occupied
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int RW = REG_ADDR_WIDTH;
`ifdef IO_BYPASS_INPUT_FORWARD_EN
  localparam int NC = DEPTH + 1;
`else
  localparam int NC = DEPTH;
`endif
  logic [DEPTH-1:0]                 r_valid, r_dv;
  logic [DEPTH-1:0][RW-1:0]         r_reg;
  logic [DEPTH-1:0][SW-1:0]         r_strb;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] r_data;
  logic                             w_res, w_dv0;
  logic [DATA_WIDTH-1:0]            w_data0;
  logic [NC-1:0]                    w_cv, w_cdv;
  logic [NC-1:0][RW-1:0]            w_creg;
  logic [NC-1:0][SW-1:0]            w_cstrb;
  logic [NC-1:0][DATA_WIDTH-1:0]    w_cdata;
  logic [NUM_READ-1:0][SW-1:0]      w_pend;

  // slot 0 as seen after this cycle's resolve; shifted into slot 1 on advance
  assign w_res   = i_resolve_valid & r_valid[0] & ~r_dv[0];
  assign w_data0 = w_res ? i_resolve_data : r_data[0];
  assign w_dv0   = r_dv[0] | w_res;

  always_ff @(posedge i_clock)
    if (i_reset) begin
      r_valid <= '0;
      r_dv    <= '0;
    end else if (i_flush) r_valid <= '0;
    else if (i_advance) begin
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_reg[i]   <= r_reg[i-1];
        r_strb[i]  <= r_strb[i-1];
        r_data[i]  <= (i == 1) ? w_data0 : r_data[i-1];
        r_dv[i]    <= (i == 1) ? w_dv0 : r_dv[i-1];
      end
      r_valid[0] <= i_in_valid & (|i_in_register);
      r_reg[0]   <= i_in_register;
      r_strb[0]  <= i_in_strobe;
      r_data[0]  <= i_in_data;
      r_dv[0]    <= i_in_data_valid;
    end else begin
      r_data[0] <= w_data0;
      r_dv[0]   <= w_dv0;
    end

  // lookup candidates, index 0 youngest
`ifdef IO_BYPASS_INPUT_FORWARD_EN
  assign w_cv    = {r_valid, i_advance & i_in_valid & ~i_flush & ~i_reset & (|i_in_register)};
  assign w_cdv   = {r_dv, i_in_data_valid};
  assign w_creg  = {r_reg, i_in_register};
  assign w_cstrb = {r_strb, i_in_strobe};
  assign w_cdata = {r_data, i_in_data};
`else
  assign w_cv    = r_valid;
  assign w_cdv   = r_dv;
  assign w_creg  = r_reg;
  assign w_cstrb = r_strb;
  assign w_cdata = r_data;
`endif

  // scan oldest to youngest so the youngest provider wins each byte
  always_comb begin
    o_read_data  = i_read_regfile;
    o_read_stall = '0;
    w_pend       = '0;
    for (int r = 0; r < NUM_READ; r++) begin
      for (int b = 0; b < SW; b++)
        for (int k = NC - 1; k >= 0; k--)
          if (w_cv[k] && w_creg[k] == i_read_register[r*RW +: RW] && (|i_read_register[r*RW +: RW]) && w_cstrb[k][b]) begin
            o_read_data[r*DATA_WIDTH + b*8 +: 8] = w_cdata[k][b*8 +: 8];
            w_pend[r][b] = ~w_cdv[k];
          end
      o_read_stall[r] = |w_pend[r];
    end
  end

  assign o_history_occupied = r_valid;
endmodule

// File: tb/tb_io_bypass_history.sv
// tb_io_bypass_history: directed and random checks of io_bypass_history against a queue-based history model.
module tb_io_bypass_history;
  localparam int D = 2;
  typedef struct {
    logic        v;
    logic [4:0]  rg;
    logic [3:0]  st;
    logic [31:0] d;
    logic        dv;
  } ent_t;

  logic clk = 0, rst = 1, flush = 0, adv = 0, iv = 0, idv = 0, res_v = 0;
  logic [4:0] ireg = 0;
  logic [3:0] istrb = 0;
  logic [31:0] idata = 0, res_d = 0;
  logic [1:0][4:0] rd_reg = '0;
  logic [1:0][31:0] rf = '0, rdata;
  logic [1:0] stall;
  logic [D-1:0] occ;
  int checks = 0, errors = 0;
  ent_t hist[D];

  always #5 clk = ~clk;

  io_bypass_history dut (
    .i_clock(clk), .i_reset(rst), .i_flush(flush), .i_advance(adv), .i_in_valid(iv),
    .i_in_register(ireg), .i_in_strobe(istrb), .i_in_data(idata), .i_in_data_valid(idv),
    .i_resolve_valid(res_v), .i_resolve_data(res_d), .i_read_register(rd_reg),
    .i_read_regfile(rf), .o_read_data(rdata), .o_read_stall(stall), .o_history_occupied(occ)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void ref_read(input logic [4:0] rr, input logic [31:0] rfv, output logic [31:0] d, output logic st);
    ent_t c[$];
    c = {};
`ifdef IO_BYPASS_INPUT_FORWARD_EN
    if (adv && iv && !flush && !rst) c.push_back('{1'b1, ireg, istrb, idata, idv});
`endif
    for (int i = 0; i < D; i++) c.push_back(hist[i]);
    d = rfv;
    st = 0;
    for (int b = 0; b < 4; b++)
      foreach (c[k])
        if (c[k].v && c[k].rg == rr && rr != 0 && c[k].st[b]) begin
          d[b*8 +: 8] = c[k].d[b*8 +: 8];
          if (!c[k].dv) st = 1;
          break;
        end
  endfunction

  task automatic settle();
    logic [31:0] ed;
    logic es;
    logic [D-1:0] eo;
    #4;
    for (int r = 0; r < 2; r++) begin
      ref_read(rd_reg[r], rf[r], ed, es);
      chk($sformatf("model_data%0d", r), rdata[r], ed);
      chk($sformatf("model_stall%0d", r), {31'b0, stall[r]}, {31'b0, es});
    end
    for (int i = 0; i < D; i++) eo[i] = hist[i].v;
    chk("model_occ", {{(32-D){1'b0}}, occ}, {{(32-D){1'b0}}, eo});
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) for (int i = 0; i < D; i++) begin hist[i].v = 0; hist[i].dv = 0; end
    else if (flush) for (int i = 0; i < D; i++) hist[i].v = 0;
    else begin
      if (res_v && hist[0].v && !hist[0].dv) begin hist[0].d = res_d; hist[0].dv = 1; end
      if (adv) begin
        for (int i = D - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = '{iv && ireg != 0, ireg, istrb, idata, idv};
      end
    end
    #1;
  endtask

  task automatic push(input logic [4:0] rg, input logic [3:0] st, input logic [31:0] d, input logic dv);
    adv = 1; iv = 1; ireg = rg; istrb = st; idata = d; idv = dv;
    settle();
    tick();
    adv = 0; iv = 0;
  endtask

  initial begin
    for (int i = 0; i < D; i++) hist[i] = '{0, 0, 0, 0, 0};
    rd_reg[0] = 5; rf[0] = 32'h11223344;
    tick();
    settle();
    chk("reset_data", rdata[0], 32'h11223344);
    chk("reset_stall", {30'b0, stall}, 32'h0);
    chk("reset_occ", {{(32-D){1'b0}}, occ}, 32'h0);
    tick();
    rst = 0;
    push(5, 4'hF, 32'hAABBCCDD, 1);
    push(5, 4'h3, 32'h00001234, 1);
    rf[0] = 0;
    settle();
    chk("merge_data", rdata[0], 32'hAABB1234);
    chk("merge_stall", {31'b0, stall[0]}, 32'h0);
    tick();
    push(6, 4'hF, 32'h66666666, 1);
    settle();
    chk("occ_full", {{(32-D){1'b0}}, occ}, 32'h3);
    tick();
    push(7, 4'hF, 32'h0, 0);
    rd_reg[0] = 7;
    settle();
    chk("pending_stall", {31'b0, stall[0]}, 32'h1);
    res_v = 1; res_d = 32'hCAFEF00D; adv = 1;
    tick();
    res_v = 0; adv = 0;
    settle();
    chk("resolved_data", rdata[0], 32'hCAFEF00D);
    chk("resolved_stall", {31'b0, stall[0]}, 32'h0);
    tick();
    push(5, 4'hF, 32'h1, 1);
    push(7, 4'hF, 32'h2, 1);
    flush = 1; adv = 1; iv = 1; ireg = 5;
    settle();
    tick();
    flush = 0; adv = 0; iv = 0;
    rd_reg[0] = 5; rf[0] = 32'h12345678;
    settle();
    chk("flush_occ", {{(32-D){1'b0}}, occ}, 32'h0);
    chk("flush_data", rdata[0], 32'h12345678);
    tick();
    push(0, 4'hF, 32'hFFFFFFFF, 1);
    rd_reg[0] = 0; rf[0] = 0;
    settle();
    chk("r0_data", rdata[0], 32'h0);
    chk("r0_stall", {31'b0, stall[0]}, 32'h0);
    chk("r0_slot0", {31'b0, occ[0]}, 32'h0);
    tick();
    rd_reg[1] = 9; rf[1] = 32'h1;
    adv = 1; iv = 1; ireg = 9; istrb = 4'hF; idata = 32'h55; idv = 1;
    settle();
`ifdef IO_BYPASS_INPUT_FORWARD_EN
    chk("fwd_same_cycle", rdata[1], 32'h55);
`else
    chk("fwd_same_cycle", rdata[1], 32'h1);
`endif
    tick();
    adv = 0; iv = 0;
    settle();
    chk("fwd_next_cycle", rdata[1], 32'h55);
    tick();
    for (int n = 0; n < 400; n++) begin
      flush = ($urandom_range(0, 19) == 0);
      adv = ($urandom_range(0, 9) < 7);
      iv = $urandom_range(0, 1);
      ireg = 5'($urandom_range(0, 3));
      istrb = 4'($urandom);
      idata = $urandom;
      idv = $urandom_range(0, 1);
      res_v = $urandom_range(0, 1);
      res_d = $urandom;
      for (int r = 0; r < 2; r++) begin
        rd_reg[r] = 5'($urandom_range(0, 3));
        rf[r] = $urandom;
      end
      settle();
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
